// File: rtl/mult_scheduler_pkg.sv
// rtl/mult_scheduler_pkg.sv - shared constants and FSM state type for the multiplier scheduler
package mult_scheduler_pkg;

    localparam int DEF_WIDTH = 192;
    localparam int DEF_N_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shiftadd_core.sv
// rtl/shiftadd_core.sv - bit-serial shift-add multiplier datapath
//
// Ports:
//   clk, rst   clock and synchronous active-low reset (clears acc and count)
//   start      load a_in/b_in, clear accumulator and bit counter
//   step       process one multiplier bit (ignored while start is high)
//   a_in, b_in operands sampled on start
//   last       the bit being processed this cycle is the final one
//   sum        accumulator value including the bit processed this cycle
module shiftadd_core
    import mult_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               last,
    output logic [2*WIDTH-1:0] sum
);

    localparam int CW = $clog2(WIDTH + 1);

    // a is kept pre-shifted by count and b is shifted down so that bit 0 is
    // always the current multiplier bit; this avoids a variable shifter.
    logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] addend;

    always_comb begin
        addend  = b_sh_q[0] ? a_sh_q : '0;
        sum     = acc_q + addend;
        last    = (count_q == CW'(WIDTH - 1));
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        count_d = count_q;
        if (start) begin
            a_sh_d  = {{WIDTH{1'b0}}, a_in};
            b_sh_d  = b_in;
            acc_d   = '0;
            count_d = '0;
        end else if (step) begin
            a_sh_d  = a_sh_q << 1;
            b_sh_d  = b_sh_q >> 1;
            acc_d   = sum;
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        a_sh_q <= a_sh_d;
        b_sh_q <= b_sh_d;
    end

endmodule

// File: rtl/mult_scheduler.sv
// rtl/mult_scheduler.sv - round-robin arbiter sharing one shift-add multiplier among requesters
//
// Ports:
//   clk, rst    clock and synchronous active-low reset
//   req_valid   per-requester request
//   req_ready   per-requester grant, one-hot or zero, only in IDLE
//   req_a/req_b packed operands, slice i belongs to requester i
//   rsp_valid   product available, held until rsp_ready
//   rsp_ready   consumer accepts product
//   rsp_id      requester that owns rsp_c
//   rsp_c       unsigned product
//   busy        operation in progress or response pending
module mult_scheduler
    import mult_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_c,
    output logic                     busy
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] rsp_c_q, rsp_c_d;

    logic [N_REQ-1:0]   grant_oh;
    logic [IDW-1:0]     grant_id;
    logic               found;
    int                 scan_idx;
    logic               hs;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic               core_start, core_step, core_last;
    logic [2*WIDTH-1:0] core_sum;

    // Round-robin scan starting at rr; only indices 0..N_REQ-1 are visited,
    // so unused id encodings can never win.
    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (!found && req_valid[scan_idx]) begin
                found              = 1'b1;
                grant_id           = IDW'(scan_idx);
                grant_oh[scan_idx] = 1'b1;
            end
        end
    end

    assign req_ready = (rst && state_q == ST_IDLE) ? grant_oh : '0;
    assign hs        = |(req_valid & req_ready);
    assign a_sel     = req_a[int'(grant_id)*WIDTH +: WIDTH];
    assign b_sel     = req_b[int'(grant_id)*WIDTH +: WIDTH];

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        core_start  = 1'b0;
        core_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    core_start = 1'b1;
                    rsp_id_d   = grant_id;
                    rr_d       = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + IDW'(1);
                    // A zero operand needs no iterations: answer next cycle.
                    if (a_sel == '0 || b_sel == '0) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_c_d     = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_c_d     = core_sum;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_c_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;
    assign busy      = (state_q != ST_IDLE);

    shiftadd_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (core_start),
        .step  (core_step),
        .a_in  (a_sel),
        .b_in  (b_sel),
        .last  (core_last),
        .sum   (core_sum)
    );

endmodule
